phy_free_list: RTL and testbench
================================

# phy_free_list

Circular free list of physical register tags for the rename/dispatch stage. Supplies up to two fresh destination tags per cycle to the renamer and takes back up to two released tags per cycle from the reorder-buffer commit port (the previous physical mapping of each committed destination). Its `allocatable` output feeds the dispatch stall logic alongside the reorder buffer's own `allocatable`.

## Interface
- `PHY_NUM`, 64: total physical registers.
- `ARCH_NUM`, 32: architectural registers; tags 0..ARCH_NUM-1 are mapped at reset.
- `TAG_W`, 6: tag width, equal to `PHY_REG_SEL`.
- `DEPTH` (local): PHY_NUM-ARCH_NUM = 32. `PTR_W` (local): log2(DEPTH) = 5.

Ports:
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `req1` in 1: dispatch slot 1 needs a destination tag.
- `req2` in 1: dispatch slot 2 needs a destination tag.
- `stall_DP` in 1: dispatch stalled; no allocation is consumed.
- `alloc_tag_1` out TAG_W: tag for the first requesting slot.
- `alloc_tag_2` out TAG_W: tag for slot 2.
- `allocatable` out 1: free count ≥ number of requests.
- `free_count` out PTR_W+1: current number of free tags.
- `rel_en1` in 1: commit slot 1 releases a tag (commit_valid1 && writes a register).
- `rel_en2` in 1: same for commit slot 2.
- `rel_tag_1` in TAG_W: released tag, slot 1.
- `rel_tag_2` in TAG_W: released tag, slot 2.
- `ckpt_save` in 1: snapshot the read pointer (branch dispatched).
- `prmiss` in 1: branch misprediction; restore the snapshot.

## Operation
- Storage: DEPTH-entry tag array, read pointer `head`, write pointer `tail`, counter `count` (PTR_W+1 bits). Pointers increment mod DEPTH with natural PTR_W-bit wrap.
- Reset values: `entry[i] = ARCH_NUM+i`, `head = 0`, `tail = 0`, `count = DEPTH`. Consequently `allocatable = 1`, `free_count = 32`, `alloc_tag_1 = 32`, `alloc_tag_2 = 33`.
- Request count is n = req1 + req2.
- Tag assignment:
  - If `req1` is set, `alloc_tag_1 = entry[head]`.
  - `alloc_tag_2 = entry[head+1]` when both requests are set, else `entry[head]`. A lone `req2` takes the head entry.
- `allocatable = (count >= n)`, computed combinationally from the current count only. Released tags are not bypassed.
- Consume: when `~stall_DP && allocatable && ~prmiss`, head advances by n. If `stall_DP` is low while `allocatable` is 0, nothing is consumed.
- Release:
  - Each enabled slot with a nonzero tag writes `entry[tail]`; slot 1 is written first, then slot 2.
  - Tail advances by the number of writes.
  - Tag 0 (hard-wired x0) is silently dropped.
- Count update per cycle: count + writes − consumed.
- Simultaneous allocate and release in the same cycle is legal, including when count = 0 with release.
- Overflow is impossible by construction: at most PHY_NUM − ARCH_NUM tags are ever free.
- Recovery (see Configuration): on `prmiss`, `head <= ckpt_head` and `count <= count + (head − ckpt_head) mod DEPTH + writes`. Releases in the same cycle are still applied, because they come from commits older than the branch.
- `ckpt_save` together with `prmiss` in the same cycle: `prmiss` wins and the save is dropped.

## Timing
- `alloc_tag_*`, `allocatable` and `free_count` are combinational from state, valid in the same cycle as the request.
- Pointer, count and array updates take effect at the posedge.
- A released tag is allocatable in the cycle after release (1-cycle latency).
- The snapshot captures `head` after that cycle's consume, i.e. the pointer value seen by the next instruction.
- `reset` mid-operation restores the reset state at the next edge and overrides all other inputs.

## Configuration
- `FREELIST_RECOVERY_EN` defined:
  - A single checkpoint register `ckpt_head` exists, reset to 0.
  - `ckpt_save` and `prmiss` behave as above.
- Not defined:
  - `ckpt_save` and `prmiss` are ignored and no checkpoint register is built.
  - Allocation proceeds even in a `prmiss` cycle.

## Test plan
- Reset, then `req1 = req2 = 1` with `stall_DP = 0` for one cycle → tags 32 and 33, next cycle `free_count = 30` and `alloc_tag_1 = 34`.
- Allocate 2 per cycle for 16 cycles → `free_count = 0`, `allocatable = 0`. With `rel_en1 = 1` and `rel_tag_1 = 5`: `allocatable` stays 0 that cycle, then 1 with `alloc_tag_1 = 5`.
- Only `req2 = 1` after reset → `alloc_tag_2 = 32`, `free_count = 31`.
- Release slot 1 tag 0 and slot 2 tag 40 in the same cycle → only 40 is written, `free_count` increases by 1.
- Drain the list fully, then release two tags per cycle across the tail wrap (tail 31 → 0) → tags are allocated back in release order.
- Recovery (`FREELIST_RECOVERY_EN`):
  - `ckpt_save` at head = 4, then allocate 6 tags, then `prmiss` with one release of tag 7 → head = 4, count = prior + 6 + 1, `alloc_tag_1` equals the tag first handed out after the save.

Source files
------------

// File: rtl/phy_free_list.sv
// phy_free_list: circular free list of physical register tags.
// Hands out up to two fresh destination tags per cycle and takes back up to
// two released tags per cycle from commit. Tag 0 is hard-wired and never freed.
// Optional branch recovery (single read-pointer checkpoint) is built only when
// the macro FREELIST_RECOVERY_EN is defined.
module phy_free_list #(
    parameter int unsigned PHY_NUM  = 64,
    parameter int unsigned ARCH_NUM = 32,
    parameter int unsigned TAG_W    = 6
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     req1,
    input  logic                                     req2,
    input  logic                                     stall_DP,
    output logic [TAG_W-1:0]                         alloc_tag_1,
    output logic [TAG_W-1:0]                         alloc_tag_2,
    output logic                                     allocatable,
    output logic [$clog2(PHY_NUM-ARCH_NUM):0]        free_count,
    input  logic                                     rel_en1,
    input  logic                                     rel_en2,
    input  logic [TAG_W-1:0]                         rel_tag_1,
    input  logic [TAG_W-1:0]                         rel_tag_2,
    input  logic                                     ckpt_save,
    input  logic                                     prmiss
);

    localparam int unsigned DEPTH = PHY_NUM - ARCH_NUM;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW-1:0]    n_req;
    logic [CW-1:0]    n_wr;
    logic [CW-1:0]    consume_n;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] head_adv;
    logic [PTR_W-1:0] tail_w2;
    logic             wr1;
    logic             wr2;
    logic             consume;
    logic             recover;

`ifdef FREELIST_RECOVERY_EN
    logic [PTR_W-1:0] ckpt_q, ckpt_d;
    logic [PTR_W-1:0] rec_back;

    assign recover = prmiss;
`else
    // Recovery inputs are accepted but have no effect in this build.
    logic unused_recovery_inputs;

    assign recover                = 1'b0;
    assign unused_recovery_inputs = ckpt_save ^ prmiss;
`endif

    // Request/release decode and combinational outputs from current state.
    always_comb begin
        n_req       = CW'(req1) + CW'(req2);
        allocatable = (count_q >= n_req);
        free_count  = count_q;
        head_p1     = head_q + 1'b1;
        alloc_tag_1 = entry_q[head_q];
        alloc_tag_2 = (req1 && req2) ? entry_q[head_p1] : entry_q[head_q];

        // Releasing tag 0 is a no-op: x0 is never renamed.
        wr1     = rel_en1 && (rel_tag_1 != '0);
        wr2     = rel_en2 && (rel_tag_2 != '0);
        n_wr    = CW'(wr1) + CW'(wr2);
        tail_w2 = tail_q + {{(PTR_W-1){1'b0}}, wr1};
        tail_d  = tail_q + n_wr[PTR_W-1:0];

        consume   = !stall_DP && allocatable && !recover;
        consume_n = consume ? n_req : '0;
        head_adv  = head_q + consume_n[PTR_W-1:0];
    end

    // Next head/count, including checkpoint restore when recovery is built.
    always_comb begin
        head_d  = head_adv;
        count_d = count_q + n_wr - consume_n;
`ifdef FREELIST_RECOVERY_EN
        ckpt_d   = ckpt_q;
        rec_back = head_q - ckpt_q;
        if (prmiss) begin
            // Tags handed out since the checkpoint return to the free pool;
            // same-cycle releases are from older commits and still count.
            head_d  = ckpt_q;
            count_d = count_q + {1'b0, rec_back} + n_wr;
        end else if (ckpt_save) begin
            // Snapshot the pointer the next instruction will see.
            ckpt_d = head_adv;
        end
`endif
    end

    // Pointer, count and checkpoint registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(DEPTH);
`ifdef FREELIST_RECOVERY_EN
            ckpt_q  <= '0;
`endif
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef FREELIST_RECOVERY_EN
            ckpt_q  <= ckpt_d;
`endif
        end
    end

    // Tag array: reset holds the unmapped tags, releases write at tail in slot order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= TAG_W'(ARCH_NUM + i);
            end
        end else begin
            if (wr1) begin
                entry_q[tail_q] <= rel_tag_1;
            end
            if (wr2) begin
                entry_q[tail_w2] <= rel_tag_2;
            end
        end
    end

endmodule

// File: tb/tb_phy_free_list.sv
// Self-checking bench for phy_free_list: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based free-pool model.
module tb_phy_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1, req2, stall_DP;
    logic [5:0] alloc_tag_1, alloc_tag_2;
    logic       allocatable;
    logic [5:0] free_count;
    logic       rel_en1, rel_en2;
    logic [5:0] rel_tag_1, rel_tag_2;
    logic       ckpt_save, prmiss;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phy_free_list dut (
        .clk        (clk),
        .reset      (reset),
        .req1       (req1),
        .req2       (req2),
        .stall_DP   (stall_DP),
        .alloc_tag_1(alloc_tag_1),
        .alloc_tag_2(alloc_tag_2),
        .allocatable(allocatable),
        .free_count (free_count),
        .rel_en1    (rel_en1),
        .rel_en2    (rel_en2),
        .rel_tag_1  (rel_tag_1),
        .rel_tag_2  (rel_tag_2),
        .ckpt_save  (ckpt_save),
        .prmiss     (prmiss)
    );

    typedef struct {
        logic       r1, r2, st, e1;
        logic [5:0] t1;
        logic       e2;
        logic [5:0] t2;
        logic [5:0] x1, x2;
        logic       xa;
        logic [5:0] xf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic st,
                         input logic e1, input logic [5:0] t1,
                         input logic e2, input logic [5:0] t2,
                         input logic sv, input logic pm);
        req1 = r1; req2 = r2; stall_DP = st;
        rel_en1 = e1; rel_tag_1 = t1; rel_en2 = e2; rel_tag_2 = t2;
        ckpt_save = sv; prmiss = pm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Randomized-phase model state: free pool in allocation order, tags handed
    // out since the last checkpoint, and tags currently mapped (releasable).
    int freeq[$];
    int since[$];
    int busy[$];

    initial begin
        reset = 1'b1;
        idle();
        do_reset();

        // ---------------- directed vector table ----------------
        //             r1 r2 st e1 t1  e2 t2  x1  x2  xa xf
        tbl[0] = '{1, 1, 0, 0, 6'd0, 0, 6'd0, 6'd32, 6'd33, 1, 6'd32};
        tbl[1] = '{0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd0, 6'd34, 1, 6'd30};
        tbl[2] = '{1, 1, 1, 0, 6'd0, 0, 6'd0, 6'd35, 6'd36, 1, 6'd29};
        tbl[3] = '{0, 0, 0, 1, 6'd0, 1, 6'd40, 6'd0, 6'd0, 1, 6'd29};
        tbl[4] = '{1, 0, 0, 0, 6'd0, 0, 6'd0, 6'd35, 6'd0, 1, 6'd30};
        tbl[5] = '{1, 1, 0, 0, 6'd0, 0, 6'd0, 6'd36, 6'd37, 1, 6'd29};
        tbl[6] = '{0, 0, 0, 0, 6'd0, 0, 6'd0, 6'd0, 6'd0, 1, 6'd27};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].r1, tbl[i].r2, tbl[i].st, tbl[i].e1, tbl[i].t1,
                  tbl[i].e2, tbl[i].t2, 0, 0);
            @(negedge clk);
            if (tbl[i].r1) chk($sformatf("vec%0d_tag1", i), alloc_tag_1, tbl[i].x1);
            if (tbl[i].r2) chk($sformatf("vec%0d_tag2", i), alloc_tag_2, tbl[i].x2);
            chk($sformatf("vec%0d_allocatable", i), allocatable, tbl[i].xa);
            chk($sformatf("vec%0d_free_count", i), free_count, tbl[i].xf);
            step();
        end

        // ---------------- reset overrides other inputs ----------------
        drive(1, 1, 0, 1, 6'd9, 1, 6'd10, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 1, 1, 0, 6'd0, 0, 6'd0, 0, 0);
        @(negedge clk);
        chk("midreset_free_count", free_count, 32);
        chk("midreset_tag1", alloc_tag_1, 32);
        chk("midreset_tag2", alloc_tag_2, 33);
        step();

        // ---------------- drain, empty, release latency ----------------
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
            @(negedge clk);
            chk($sformatf("drain%0d_tag1", k), alloc_tag_1, 32 + 2 * k);
            chk($sformatf("drain%0d_tag2", k), alloc_tag_2, 33 + 2 * k);
            step();
        end
        drive(1, 0, 0, 1, 6'd5, 0, 6'd0, 0, 0);
        @(negedge clk);
        chk("empty_free_count", free_count, 0);
        chk("empty_allocatable", allocatable, 0);
        step();
        drive(1, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        @(negedge clk);
        chk("rel_latency_allocatable", allocatable, 1);
        chk("rel_latency_tag1", alloc_tag_1, 5);
        chk("rel_latency_free_count", free_count, 1);
        step();

        // ---------------- walk tail to 31, then release across the wrap ----------------
        for (int k = 0; k < 30; k++) begin
            drive(1, 0, 0, 1, 6'(10 + k), 0, 6'd0, 0, 0);
            @(negedge clk);
            if (k > 0) chk($sformatf("walk%0d_tag1", k), alloc_tag_1, 10 + k - 1);
            step();
        end
        drive(1, 0, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        step();
        drive(0, 0, 0, 1, 6'd50, 1, 6'd51, 0, 0);
        @(negedge clk);
        chk("wrap_pre_free_count", free_count, 0);
        step();
        drive(0, 0, 0, 1, 6'd52, 1, 6'd53, 0, 0);
        step();
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        @(negedge clk);
        chk("wrap_free_count", free_count, 4);
        chk("wrap_tag1_a", alloc_tag_1, 50);
        chk("wrap_tag2_a", alloc_tag_2, 51);
        step();
        @(negedge clk);
        chk("wrap_tag1_b", alloc_tag_1, 52);
        chk("wrap_tag2_b", alloc_tag_2, 53);
        step();
        idle();
        @(negedge clk);
        chk("wrap_end_free_count", free_count, 0);

        // ---------------- checkpoint / misprediction ----------------
        do_reset();
`ifdef FREELIST_RECOVERY_EN
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        step();
        // Save in a consuming cycle: snapshot is head after consume (4).
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 1, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
            step();
        end
        drive(1, 1, 0, 1, 6'd7, 0, 6'd0, 0, 1);
        @(negedge clk);
        chk("pre_prmiss_free_count", free_count, 22);
        step();
        idle();
        @(negedge clk);
        chk("prmiss_free_count", free_count, 29);
        chk("prmiss_tag1", alloc_tag_1, 36);
        step();
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 6'd0, 0, 6'd0, 1, 1);
        step();
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 0);
        @(negedge clk);
        chk("save_vs_prmiss_tag1", alloc_tag_1, 36);
        step();
        drive(0, 0, 0, 0, 6'd0, 0, 6'd0, 0, 1);
        step();
        idle();
        @(negedge clk);
        chk("dropped_save_tag1", alloc_tag_1, 36);
        chk("dropped_save_free_count", free_count, 29);
`else
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 1, 1);
        step();
        drive(1, 1, 0, 0, 6'd0, 0, 6'd0, 0, 1);
        step();
        idle();
        @(negedge clk);
        chk("norec_prmiss_free_count", free_count, 28);
        chk("norec_prmiss_tag1", alloc_tag_1, 36);
`endif

        // ---------------- randomized traffic vs. free-pool model ----------------
        do_reset();
        freeq.delete(); since.delete(); busy.delete();
        for (int t = 32; t < 64; t++) freeq.push_back(t);
        for (int t = 1; t < 32; t++) busy.push_back(t);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic r1, r2, st, sv, pm, e1, e2;
            logic [5:0] t1, t2;
            int allowed, n, idx;
            bit ok, cons;
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 2) == 0);
            pm = ($urandom_range(0, 7) == 0);
`ifdef FREELIST_RECOVERY_EN
            if (since.size() >= 32) pm = 1'b0;
`endif
            // Keep at least 31 tags mapped so the free pool can never exceed 32.
            allowed = busy.size() - 31;
            e1 = 1'($urandom_range(0, 1));
            t1 = 6'($urandom_range(1, 63));
            if (e1) begin
                if ($urandom_range(0, 7) == 0) t1 = 6'd0;
                else if (allowed > 0) begin
                    idx = $urandom_range(0, busy.size() - 1);
                    t1 = 6'(busy[idx]); busy.delete(idx); allowed--;
                end else e1 = 1'b0;
            end
            e2 = 1'($urandom_range(0, 1));
            t2 = 6'($urandom_range(1, 63));
            if (e2) begin
                if ($urandom_range(0, 7) == 0) t2 = 6'd0;
                else if (allowed > 0) begin
                    idx = $urandom_range(0, busy.size() - 1);
                    t2 = 6'(busy[idx]); busy.delete(idx); allowed--;
                end else e2 = 1'b0;
            end
            drive(r1, r2, st, e1, t1, e2, t2, sv, pm);

            n  = int'(r1) + int'(r2);
            ok = (freeq.size() >= n);
            @(negedge clk);
            chk("rnd_allocatable", allocatable, int'(ok));
            chk("rnd_free_count", free_count, freeq.size());
            if (ok && r1) chk("rnd_tag1", alloc_tag_1, freeq[0]);
            if (ok && r2) chk("rnd_tag2", alloc_tag_2, r1 ? freeq[1] : freeq[0]);

            cons = !st && ok;
`ifdef FREELIST_RECOVERY_EN
            if (pm) cons = 1'b0;
`endif
            if (cons) begin
                for (int j = 0; j < n; j++) begin
`ifdef FREELIST_RECOVERY_EN
                    since.push_back(freeq.pop_front());
`else
                    busy.push_back(freeq.pop_front());
`endif
                end
            end
`ifdef FREELIST_RECOVERY_EN
            if (pm) begin
                freeq = {since, freeq};
                since.delete();
            end
`endif
            if (e1 && t1 != 6'd0) freeq.push_back(int'(t1));
            if (e2 && t2 != 6'd0) freeq.push_back(int'(t2));
`ifdef FREELIST_RECOVERY_EN
            if (sv && !pm) begin
                busy = {busy, since};
                since.delete();
            end
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
